// File: rtl/alu_mult_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package alu_mult_seq_pkg;

  localparam int         WIDTH      = 16;
  localparam int         ITER_DEF   = 16;
  localparam logic [3:0] ALU_OP_ADD = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NEGA = 3'd1,
    ST_NEGB = 3'd2,
    ST_MUL  = 3'd3,
    ST_FIXL = 3'd4,
    ST_FIXH = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/alu_mult_ctl_fsm.sv
// Multiplier sequencer control: state, iteration counter, next-state. No added latency;
// any ALU-using state holds while the grant is low, kill forces IDLE on the next edge.
module alu_mult_ctl_fsm
  import alu_mult_seq_pkg::*;
#(
  parameter int ITER  = ITER_DEF,
  parameter int CNT_W = $clog2(ITER)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_signed,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             neg_b,
  input  logic             neg,
  input  logic             lo_lsb,
  input  logic             alu_gnt,
  input  logic             kill,
  output state_t           state,
  output logic [CNT_W-1:0] cnt,
  output logic             accept,
  output logic             advance,
  output logic             alu_need
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    alu_need  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = (state == ST_IDLE) && req_valid && !kill;

    case (state)
      ST_NEGA, ST_NEGB, ST_FIXL, ST_FIXH: alu_need = 1'b1;
      ST_MUL:                             alu_need = lo_lsb;
      default:                            alu_need = 1'b0;
    endcase

    // A state without an ALU need always advances; otherwise it waits for the grant.
    advance = !alu_need || alu_gnt;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          if (req_signed && a_msb)      state_nxt = ST_NEGA;
          else if (req_signed && b_msb) state_nxt = ST_NEGB;
          else                          state_nxt = ST_MUL;
        end
      end
      ST_NEGA: if (advance) state_nxt = neg_b ? ST_NEGB : ST_MUL;
      ST_NEGB: if (advance) state_nxt = ST_MUL;
      ST_MUL: begin
        if (advance) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state_nxt = neg ? ST_FIXL : ST_DONE;
        end
      end
      ST_FIXL: if (advance) state_nxt = ST_FIXH;
      ST_FIXH: if (advance) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (kill) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: rtl/alu_mult_seq.sv
// 16x16->32 shift-add multiplier on a shared ALU; done 17 cycles after accept (unsigned, no stalls).
// Accepts one request at a time (req_ready only in IDLE); stalls with stable ALU operands while alu_gnt=0.
module alu_mult_seq
  import alu_mult_seq_pkg::*;
#(
  parameter logic [3:0] ADD_OP = ALU_OP_ADD,
  parameter int         ITER   = ITER_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic               req_signed,
  input  logic               kill,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               alu_req,
  input  logic               alu_gnt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  output logic               alu_inv_a,
  output logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_out,
  input  logic               alu_cout
);

  localparam int CNT_W = $clog2(ITER);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               advance;
  logic               alu_need;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               neg;
  logic               neg_b;
  logic               fix_c;
  logic [2*WIDTH-1:0] prod_q;

  alu_mult_ctl_fsm #(
    .ITER  (ITER),
    .CNT_W (CNT_W)
  ) u_ctl (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_signed (req_signed),
    .a_msb      (req_a[WIDTH-1]),
    .b_msb      (req_b[WIDTH-1]),
    .neg_b      (neg_b),
    .neg        (neg),
    .lo_lsb     (lo[0]),
    .alu_gnt    (alu_gnt),
    .kill       (kill),
    .state      (state),
    .cnt        (cnt),
    .accept     (accept),
    .advance    (advance),
    .alu_need   (alu_need)
  );

  assign req_ready = (state == ST_IDLE) && !kill;
  assign done      = (state == ST_DONE) && !kill;
  // Expose the fresh result in the done cycle; prod_q holds it afterwards.
  assign product   = done ? {hi, lo} : prod_q;
  assign alu_req   = alu_need;
  assign alu_op    = ADD_OP;

  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_cin   = 1'b0;
    alu_inv_a = 1'b0;
    case (state)
      ST_NEGA: begin alu_a = mcand; alu_inv_a = 1'b1; alu_cin = 1'b1; end
      ST_NEGB: begin alu_a = lo;    alu_inv_a = 1'b1; alu_cin = 1'b1; end
      ST_MUL: begin
        if (lo[0]) begin
          alu_a = hi;
          alu_b = mcand;
        end
      end
      ST_FIXL: begin alu_a = lo; alu_inv_a = 1'b1; alu_cin = 1'b1;  end
      ST_FIXH: begin alu_a = hi; alu_inv_a = 1'b1; alu_cin = fix_c; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      hi     <= '0;
      lo     <= '0;
      neg    <= 1'b0;
      neg_b  <= 1'b0;
      fix_c  <= 1'b0;
      prod_q <= '0;
    end else if (accept) begin
      mcand <= req_a;
      lo    <= req_b;
      hi    <= '0;
      neg   <= req_signed && (req_a[WIDTH-1] ^ req_b[WIDTH-1]);
      neg_b <= req_signed && req_b[WIDTH-1];
    end else if (!kill && advance) begin
      case (state)
        ST_NEGA: mcand <= alu_out;
        ST_NEGB: lo    <= alu_out;
        ST_MUL: begin
          if (lo[0]) {hi, lo} <= {alu_cout, alu_out, lo[WIDTH-1:1]};
          else       {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
        end
        ST_FIXL: begin
          lo    <= alu_out;
          fix_c <= alu_cout;
        end
        ST_FIXH: hi     <= alu_out;
        ST_DONE: prod_q <= {hi, lo};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed-vector bench for alu_mult_seq with a behavioural shared ALU.
module tb_alu_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_signed;
  logic        kill;
  logic        done;
  logic [31:0] product;
  logic        alu_req;
  logic        alu_gnt;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic        alu_inv_a;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_cout;

  int n_cmp = 0;
  int n_mis = 0;

  alu_mult_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .kill       (kill),
    .done       (done),
    .product    (product),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_inv_a  (alu_inv_a),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU as the parent provides it: A (optionally inverted) + B + Cin.
  logic [16:0] alu_sum;
  always_comb begin
    alu_sum  = {1'b0, (alu_inv_a ? ~alu_a : alu_a)} + {1'b0, alu_b} + {16'b0, alu_cin};
    alu_out  = alu_sum[15:0];
    alu_cout = alu_sum[16];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Handshake at a negedge; returns at the negedge of the first busy cycle.
  task automatic start_req(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_signed = sgn;
    #1;
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_a      = 16'hDEAD;
    req_b      = 16'hBEEF;
    req_signed = 1'b1;
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input logic [31:0] exp_p, input int exp_lat,
                         input int exp_grants, input int stall_at);
    int          cyc;
    int          grants;
    bit          busy_ok;
    bit          stable_ok;
    logic [15:0] sa;
    logic [15:0] sb;
    start_req(a, b, sgn);
    cyc = 1; grants = 0; busy_ok = 1'b1; stable_ok = 1'b1; sa = '0; sb = '0;
    while (cyc < 100) begin
      alu_gnt = !(stall_at != 0 && cyc >= stall_at && cyc < stall_at + 3);
      #1;
      if (done) break;
      if (req_ready) busy_ok = 1'b0;
      if (alu_req && alu_gnt) grants++;
      if (stall_at != 0 && cyc == stall_at) begin
        sa = alu_a;
        sb = alu_b;
      end
      if (stall_at != 0 && cyc > stall_at && cyc <= stall_at + 3 &&
          (alu_a !== sa || alu_b !== sb || !alu_req)) stable_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    alu_gnt = 1'b1;
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_product_at_done"}, product, exp_p);
    check({tag, "_alu_grants"}, grants, exp_grants);
    check({tag, "_busy_not_ready"}, busy_ok, 1);
    check({tag, "_ready_in_done"}, req_ready, 0);
    if (stall_at != 0) check({tag, "_stall_stable"}, stable_ok, 1);
    @(negedge clk);
    #1;
    check({tag, "_ready_after"}, req_ready, 1);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_product_held"}, product, exp_p);
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_signed = 1'b0;
    kill       = 1'b0;
    alu_gnt    = 1'b1;
    #12;
    check("rst_ready",   req_ready, 1);
    check("rst_done",    done, 0);
    check("rst_product", product, 32'h0);
    check("rst_alu_req", alu_req, 0);
    check("rst_alu_a",   alu_a, 0);
    check("rst_alu_op",  alu_op, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_mul("u3x5",      16'h0003, 16'h0005, 1'b0, 32'h0000000F, 17, 2,  0);
    run_mul("uffxff",    16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 17, 16, 0);
    run_mul("s_m3x5",    16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 20, 5,  0);
    run_mul("s_8000sq",  16'h8000, 16'h8000, 1'b1, 32'h40000000, 19, 3,  0);
    run_mul("u_stall",   16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 20, 2,  1);

    // Abort in the MUL cycle with cnt==7.
    start_req(16'h1234, 16'h5678, 1'b0);
    cyc = 1; saw_done = 1'b0;
    while (cyc < 8) begin
      #1;
      if (done) saw_done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    kill = 1'b1;
    #1;
    if (done) saw_done = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill_no_done",    saw_done, 0);
    check("kill_idle_ready", req_ready, 1);
    check("kill_alu_req",    alu_req, 0);
    check("kill_product",    product, 32'h0000FFFF);
    @(negedge clk);
    run_mul("u2x2", 16'h0002, 16'h0002, 1'b0, 32'h00000004, 17, 1, 0);

    // kill and req_valid together in IDLE: the request must not be taken.
    req_valid = 1'b1;
    kill      = 1'b1;
    req_a     = 16'h0007;
    req_b     = 16'h0007;
    req_signed = 1'b0;
    #1;
    check("kill_vs_req_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    kill      = 1'b0;
    #1;
    check("kill_vs_req_idle", req_ready, 1);
    @(negedge clk);

    // Asynchronous reset while in FIXL of -3*5.
    start_req(16'hFFFD, 16'h0005, 1'b1);
    cyc = 1;
    while (cyc < 18) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    check("fixl_alu_req", alu_req, 1);
    check("fixl_inv_a",   alu_inv_a, 1);
    check("fixl_alu_a",   alu_a, 32'h0000000F);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready",   req_ready, 1);
    check("arst_done",    done, 0);
    check("arst_product", product, 32'h0);
    check("arst_alu_req", alu_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
Multi-cycle 16x16 -> 32-bit multiply sequencer. It computes the product by shift-and-add, borrowing the shared 16-bit ALU's adder for every addition and negation. The ALU is shared with the execute stage, so the block requests it through a req/gnt pair and stalls when no grant is given. It sits beside the execute stage and takes one multiply request at a time.

Parameters:
ADD_OP, 4'b0100, ALU Op encoding for A+B+Cin.
ITER, 16, number of shift-add iterations; must equal operand width (only 16 supported).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  multiply request
req_ready  out  1  request accepted when req_valid & req_ready
req_a  in  16  multiplicand
req_b  in  16  multiplier
req_signed  in  1  1 = two's-complement operands, 0 = unsigned
kill  in  1  synchronous abort; return to IDLE
done  out  1  one-cycle pulse: product valid
product  out  32  result; held until next accept
alu_req  out  1  ALU needed this cycle
alu_gnt  in  1  ALU granted this cycle (combinational from arbiter)
alu_a  out  16  to ALU A
alu_b  out  16  to ALU B
alu_cin  out  1  to ALU Cin
alu_inv_a  out  1  to ALU invA
alu_op  out  4  to ALU Op
alu_out  in  16  ALU result
alu_cout  in  1  ALU carry out

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, done=0, product=0, alu_req=0, alu_a/alu_b/alu_cin/alu_inv_a=0, alu_op=ADD_OP, counter=0.
- alu_op is always ADD_OP. ALU invB and sign are tied 0 by the parent. alu_* outputs are 0 whenever alu_req=0.
- States: IDLE, NEGA, NEGB, MUL, FIXL, FIXH, DONE.
- IDLE: req_ready=1. On accept, latch the operands and neg = req_signed & (a[15]^b[15]), and clear hi=0, cnt=0.
  - Next state: NEGA if signed & a[15]; else NEGB if signed & b[15]; else MUL.
- NEGA: alu_req=1, alu_a=mcand, alu_inv_a=1, alu_b=0, alu_cin=1. On gnt: mcand<=alu_out. Next state: NEGB if signed & b[15], else MUL.
- NEGB: same as NEGA, applied to the multiplier (lo). Next state: MUL.
- MUL, one iteration per cycle:
  - If lo[0]=1: alu_req=1, alu_a=hi, alu_b=mcand, cin=0. On gnt: {hi,lo} <= {alu_cout, alu_out, lo[15:1]}, cnt++.
  - If lo[0]=0: no ALU request. {hi,lo} <= {1'b0, hi, lo[15:1]}, cnt++.
  - After the iteration with cnt==ITER-1: go to FIXL if neg, else DONE.
- FIXL: alu_a=lo, inv_a=1, b=0, cin=1. On gnt: lo<=alu_out, c<=alu_cout. Next state: FIXH.
- FIXH: alu_a=hi, inv_a=1, b=0, cin=c. On gnt: hi<=alu_out. Next state: DONE.
- DONE: done=1, product<={hi,lo}, req_ready=0. Next state: IDLE.
- Stall: in any ALU-using state with alu_gnt=0, all state is held and alu_req and operands stay asserted and stable. There is no timeout.
- Latency, no stalls, accept at cycle T0:
  - unsigned: done at T0+ITER+1 (17).
  - each NEG state adds 1 cycle; a negative result adds 2 (FIXL, FIXH).
  - each denied-grant cycle adds 1.
- Magnitude of 0x8000 is 0x8000 unsigned; 0x8000*0x8000 signed = 0x40000000, which fits.
- kill (any state): next state IDLE, done=0, product unchanged. If kill and req_valid arrive in the same IDLE cycle, kill wins and the request is not accepted.
- Zero operands follow the normal iteration count; there is no early exit.

Decomposition:
- Shared package: ALU_OP_ADD constant, state encoding constants, WIDTH=16.
- Sub-module alu_mult_ctl_fsm: state register, counter and next-state logic.
- The operand/product shift registers and ALU operand muxing stay in the top.

Test Plan:
- Unsigned 3*5, gnt tied 1 -> done exactly 17 cycles after accept, product=0x0000000F, req_ready low until the cycle after done.
- Unsigned 0xFFFF*0xFFFF -> product=0xFFFE0001; alu_req high in all 16 MUL cycles.
- Signed 0xFFFD*0x0005 (-3*5) -> product=0xFFFFFFF1, latency 20 (NEGA + FIXL + FIXH). Signed 0x8000*0x8000 -> 0x40000000, latency 19.
- Unsigned 0x00FF*0x0101 with alu_gnt low for 3 cycles during a lo[0]=1 MUL cycle -> alu_a/alu_b stable throughout the stall, latency 20, product=0x0000FFFF.
- Assert kill during MUL (cnt=7) -> IDLE next cycle, no done, prior product retained. A new request 2*2 then yields 0x00000004.
- rst_n low mid-FIXL -> immediately req_ready=1, done=0, product=0, alu_req=0.
